// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I core: drives datapath selects and strobes, counts retired instructions.
// Optional ILLEGAL_TRAP_EN macro: unrecognised opcodes park the FSM in a sticky TRAP state.
module multicycle_controller #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [2:0]           imm_src,
  output logic [3:0]           state_o,
  output logic [INSTRET_W-1:0] instret,
  output logic                 illegal_instr
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
`ifdef ILLEGAL_TRAP_EN
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
`else
    S_BEQ      = 4'd10
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 pc_write_raw, ir_write_raw, mem_write_raw, reg_write_raw;

  always_comb begin
    state_d   = state_q;
    instret_d = instret_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
`ifdef ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ:       state_d = S_FETCH;
      default:    state_d = state_q;
    endcase
    // Retirement is tied to the edge that leaves the instruction's final state.
    if (state_q == S_MEMWB || state_q == S_ALUWB || state_q == S_BEQ ||
        (state_q == S_MEMWRITE && mem_ready))
      instret_d = instret_q + INSTRET_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    adr_src       = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: reg_write_raw = 1'b1;
      S_JAL: begin
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        pc_write_raw = 1'b1;
      end
      S_BEQ: begin
        alu_src_a    = 2'b10;
        alu_op       = 2'b01;
        pc_write_raw = zero;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_SW:   imm_src = 3'b001;
      OP_BEQ:  imm_src = 3'b010;
      OP_JAL:  imm_src = 3'b011;
      default: imm_src = 3'b000;
    endcase
  end

  // Strobes are suppressed for the whole reset pulse, not just until the next edge.
  assign pc_write  = pc_write_raw  & ~rst;
  assign ir_write  = ir_write_raw  & ~rst;
  assign mem_write = mem_write_raw & ~rst;
  assign reg_write = reg_write_raw & ~rst;
  assign state_o   = state_q;
  assign instret   = instret_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_instr = (state_q == S_TRAP);
`else
  assign illegal_instr = 1'b0;
`endif

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM for the multicycle RV32I core: one shared ALU, one unified instruction/data memory and a single register-file write port, time-multiplexed across FETCH/DECODE/EXECUTE/MEM/WB steps.
- Sits beside the opcode decode and alu_decoder; drives datapath mux selects and write strobes from the latched instruction opcode.
- Stalls on a memory ready handshake.
- Keeps a retired-instruction counter.

Parameters:
- INSTRET_W, 32, width of the retired-instruction counter; wraps modulo 2^INSTRET_W.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- opcode  in  7  opcode field of the instruction register (valid from DECODE onward).
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  PC register load strobe.
- ir_write  out  1  instruction register / old-PC load strobe.
- adr_src  out  1  memory address select: 0 = PC, 1 = alu_out.
- mem_write  out  1  memory write strobe.
- reg_write  out  1  register file write strobe.
- result_src  out  2  result select: 00 = alu_out, 01 = read data, 10 = ALU result.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4.
- alu_op  out  2  to alu_decoder: 00 = add, 01 = subtract, 10 = per funct.
- imm_src  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J.
- state_o  out  4  current state encoding (debug).
- instret  out  INSTRET_W  retired-instruction count.
- illegal_instr  out  1  trap flag (see Optional Feature).

Behaviour:
- Reset: state = FETCH, instret = 0, illegal_instr = 0. While rst is high, pc_write, ir_write, mem_write and reg_write are forced 0. Other outputs take FETCH values. Reset mid-instruction aborts it without a retire.
- Outputs are Moore (combinational from state), except pc_write and ir_write in FETCH, and pc_write in BEQ. Unlisted outputs default to 0.
- imm_src decodes combinationally from opcode in every state: lw/I-type 000, sw 001, beq 010, jal 011, other 000.
- States and outputs:
  - FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10. ir_write = pc_write = mem_ready. Stays in FETCH while mem_ready=0, else goes to DECODE.
  - DECODE: a=01, b=01, alu_op=00 (branch/jump target into alu_out). Next state by opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1101111 -> JAL; 1100011 -> BEQ; other -> see Optional Feature.
  - MEMADR: a=10, b=01, alu_op=00. Goes to MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: adr_src=1, result_src=00. Holds until mem_ready, then goes to MEMWB.
  - MEMWB: result_src=01, reg_write=1. Goes to FETCH.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1. mem_write is held until mem_ready, then goes to FETCH.
  - EXECUTER: a=10, b=00, alu_op=10. Goes to ALUWB.
  - EXECUTEI: a=10, b=01, alu_op=10. Goes to ALUWB.
  - ALUWB: result_src=00, reg_write=1. Goes to FETCH.
  - JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1. Goes to ALUWB.
  - BEQ: a=10, b=00, alu_op=01, result_src=00, pc_write=zero. Goes to FETCH.
- Retire: instret increments by 1 on each clock edge that leaves MEMWB, ALUWB or BEQ, or leaves MEMWRITE with mem_ready=1. It wraps from all-ones to 0.
- Latency in cycles, zero wait states: lw 5, sw 4, R/I 4, jal 4, beq 3.
- Each mem_ready=0 cycle adds one cycle in FETCH, MEMREAD or MEMWRITE.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an unrecognised opcode in DECODE goes to TRAP. TRAP drives all strobes 0 and illegal_instr=1, and remains there until rst. No retire.
- Undefined: an unrecognised opcode in DECODE returns to FETCH with no side effects and no retire. TRAP does not exist; illegal_instr is tied 0.

Test Plan:
- rst pulsed mid-MEMREAD -> state_o = FETCH immediately (async), all strobes 0, instret = 0.
- lw (0000011), mem_ready=1 throughout -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write=1 with result_src=01 in cycle 5 only. instret increments 0 -> 1.
- sw with mem_ready low for 3 cycles in MEMWRITE -> mem_write=1 for 4 consecutive cycles, then FETCH. instret +1 only after the ready cycle.
- beq with zero=1, then a second beq with zero=0 -> pc_write=1 in BEQ only for the first. Both retire (instret +2).
- jal -> JAL cycle has pc_write=1, a=01, b=10; ALUWB has reg_write=1. imm_src=011 throughout.
- opcode 7'b1111111 -> with ILLEGAL_TRAP_EN: TRAP, illegal_instr=1 sticky, instret unchanged. Without the macro: back to FETCH next cycle.
